// File: rtl/mem_dma_pkg.sv
// Shared types for the mem_copy_dma block-move engine: FSM states and op encodings.
package mem_dma_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_MEMORY_SIZE = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_e;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_dma_if.sv
// Command and memory-port bundle between a command issuer / data_mem pair and mem_copy_dma.
interface mem_copy_dma_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int MEMORY_SIZE = 64
);
  localparam int ADDR_WIDTH = $clog2(MEMORY_SIZE);

  // Handshake: start is a one-cycle strobe honoured only while the engine is idle
  // (busy=0 and done=0); starts seen at any other time are dropped, never queued.
  // done pulses for exactly one cycle when the accepted command has finished.
  logic                  start;
  logic                  op;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH:0]   length;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_en;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport master (
    output start, op, src_addr, dst_addr, length, fill_value, mem_read_data,
    input  busy, done, mem_addr, mem_write_data, mem_write_en
  );

  modport slave (
    input  start, op, src_addr, dst_addr, length, fill_value, mem_read_data,
    output busy, done, mem_addr, mem_write_data, mem_write_en
  );

endinterface

// File: rtl/data_mem.sv
// Single-port byte memory: synchronous write, one-cycle registered read, cleared by reset.
module data_mem #(
  parameter int DATA_WIDTH  = 8,
  parameter int MEMORY_SIZE = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(MEMORY_SIZE)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic                           write_en,
  output logic [DATA_WIDTH-1:0]          read_data
);

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_SIZE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEMORY_SIZE; i++) mem_q[i] <= '0;
      read_data <= '0;
    end else begin
      if (write_en) mem_q[addr] <= write_data;
      read_data <= mem_q[addr];
    end
  end

endmodule

// File: rtl/mem_dma_top.sv
// Integration of mem_copy_dma with data_mem sharing one clock and reset.
module mem_dma_top
  import mem_dma_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           op,
  input  logic [$clog2(MEMORY_SIZE)-1:0] src_addr,
  input  logic [$clog2(MEMORY_SIZE)-1:0] dst_addr,
  input  logic [$clog2(MEMORY_SIZE):0]   length,
  input  logic [DATA_WIDTH-1:0]          fill_value,
  output logic                           busy,
  output logic                           done,
  output dma_state_e                     dbg_state_o
);

  mem_copy_dma_if #(.DATA_WIDTH(DATA_WIDTH), .MEMORY_SIZE(MEMORY_SIZE)) bus ();

  assign bus.start      = start;
  assign bus.op         = op;
  assign bus.src_addr   = src_addr;
  assign bus.dst_addr   = dst_addr;
  assign bus.length     = length;
  assign bus.fill_value = fill_value;
  assign busy           = bus.busy;
  assign done           = bus.done;

  mem_copy_dma #(.DATA_WIDTH(DATA_WIDTH), .MEMORY_SIZE(MEMORY_SIZE)) u_dma (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state_o)
  );

  data_mem #(.DATA_WIDTH(DATA_WIDTH), .MEMORY_SIZE(MEMORY_SIZE)) u_mem (
    .clk        (clk),
    .reset      (reset),
    .addr       (bus.mem_addr),
    .write_data (bus.mem_write_data),
    .write_en   (bus.mem_write_en),
    .read_data  (bus.mem_read_data)
  );

endmodule

// File: rtl/mem_copy_dma.sv
// Byte-serial copy/fill engine that is the sole address/write master of data_mem.
module mem_copy_dma
  import mem_dma_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  mem_copy_dma_if.slave  bus,
  output dma_state_e     dbg_state_o
);

  localparam int ADDR_WIDTH = $clog2(MEMORY_SIZE);
  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH + 1)'(MEMORY_SIZE);

  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  op_q, op_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;

  logic                  busy, done, we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH:0]   len_clamped;

  assign len_clamped = (bus.length > LEN_MAX) ? LEN_MAX : bus.length;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_COPY;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    op_d    = op_q;
    fill_d  = fill_q;
    busy    = 1'b0;
    done    = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          op_d   = bus.op;
          fill_d = bus.fill_value;
          rem_d  = len_clamped;
          if (len_clamped == '0)      state_d = DONE;
          else if (bus.op == OP_FILL) state_d = WR;
          else                        state_d = RD;
        end
      end
      RD: begin
        // data_mem registers mem[src] at the edge closing this cycle.
        busy    = 1'b1;
        addr    = src_q;
        state_d = WR;
      end
      WR: begin
        busy  = 1'b1;
        addr  = dst_q;
        we    = 1'b1;
        wdata = (op_q == OP_FILL) ? fill_q : bus.mem_read_data;
        src_d = src_q + ADDR_WIDTH'(1);
        dst_d = dst_q + ADDR_WIDTH'(1);
        rem_d = rem_q - (ADDR_WIDTH + 1)'(1);
        if (rem_q == (ADDR_WIDTH + 1)'(1)) state_d = DONE;
        else if (op_q == OP_FILL)          state_d = WR;
        else                               state_d = RD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.mem_addr       = addr;
  assign bus.mem_write_en   = we;
  assign bus.mem_write_data = wdata;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma against a sequential byte-move reference model.
module tb_mem_copy_dma;
  import mem_dma_pkg::*;

  localparam int DW = 8;
  localparam int MS = 64;
  localparam int AW = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  dma_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mem_copy_dma_if #(.DATA_WIDTH(DW), .MEMORY_SIZE(MS)) bus ();

  mem_copy_dma #(.DATA_WIDTH(DW), .MEMORY_SIZE(MS)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural data_mem driven by the DUT.
  logic [DW-1:0] mem [MS];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MS; i++) mem[i] <= '0;
      bus.mem_read_data <= '0;
    end else begin
      if (bus.mem_write_en) mem[bus.mem_addr] <= bus.mem_write_data;
      bus.mem_read_data <= mem[bus.mem_addr];
    end
  end

  // Reference memory image and expected write stream {addr, data}.
  logic [DW-1:0]    ref_mem [MS];
  logic [AW+DW-1:0] exp_q[$];

  task automatic clear_ref();
    for (int i = 0; i < MS; i++) ref_mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic run_cmd(input logic o, input int src, input int dst, input int len,
                         input logic [DW-1:0] fv, input bit stray, input int tail);
    int n, exp_done, exp_busy, win;
    int done_cnt, done_cyc, busy_cnt, wr_cnt;
    logic [AW+DW-1:0] got, exp;
    logic [DW-1:0] d;
    n = (len > MS) ? MS : len;
    for (int i = 0; i < n; i++) begin
      d = (o == OP_COPY) ? ref_mem[(src + i) % MS] : fv;
      ref_mem[(dst + i) % MS] = d;
      exp_q.push_back({AW'((dst + i) % MS), d});
    end
    exp_done = (n == 0) ? 1 : ((o == OP_COPY) ? 2 * n + 1 : n + 1);
    exp_busy = (n == 0) ? 0 : ((o == OP_COPY) ? 2 * n : n);
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; wr_cnt = 0;

    bus.start = 1'b1; bus.op = o; bus.src_addr = AW'(src); bus.dst_addr = AW'(dst);
    bus.length = (AW + 1)'(len); bus.fill_value = fv;
    @(posedge clk); #1;
    bus.start = 1'b0;

    win = exp_done + tail;
    for (int c = 1; c <= win; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (bus.mem_write_en) begin
        wr_cnt++;
        got = {bus.mem_addr, bus.mem_write_data};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_write cycle %0d: got addr=%0d data=%02h, required no write", c, bus.mem_addr, bus.mem_write_data);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_err++;
            $display("FAIL write_stream cycle %0d: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     c, got[AW+DW-1:DW], got[DW-1:0], exp[AW+DW-1:DW], exp[DW-1:0]);
          end
        end
      end
      if (!bus.busy) begin
        n_cmp++;
        if (bus.mem_write_en !== 1'b0 || bus.mem_addr !== '0 || bus.mem_write_data !== '0) begin
          n_err++;
          $display("FAIL idle_port cycle %0d: got we=%b addr=%0d data=%02h, required all 0", c, bus.mem_write_en, bus.mem_addr, bus.mem_write_data);
        end
      end
      if (stray && c == 2) begin
        bus.start = 1'b1; bus.op = ~o; bus.dst_addr = AW'(dst + 7); bus.length = 7'd3;
      end
      if (stray && c == 3) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    n_cmp++;
    if (done_cyc !== exp_done) begin
      n_err++;
      $display("FAIL done_cycle op=%0d len=%0d: got %0d, required %0d", o, len, done_cyc, exp_done);
    end
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL done_pulses op=%0d len=%0d: got %0d, required 1", o, len, done_cnt);
    end
    n_cmp++;
    if (busy_cnt !== exp_busy) begin
      n_err++;
      $display("FAIL busy_cycles op=%0d len=%0d: got %0d, required %0d", o, len, busy_cnt, exp_busy);
    end
    n_cmp++;
    if (wr_cnt !== n) begin
      n_err++;
      $display("FAIL write_count op=%0d len=%0d: got %0d, required %0d", o, len, wr_cnt, n);
    end
    exp_q.delete();
    for (int i = 0; i < MS; i++) begin
      n_cmp++;
      if (mem[i] !== ref_mem[i]) begin
        n_err++;
        $display("FAIL mem_image[%0d]: got %02h, required %02h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_write_en !== 1'b0 ||
        bus.mem_addr !== '0 || bus.mem_write_data !== '0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL %s: got busy=%b done=%b we=%b addr=%0d data=%02h state=%0d, required all 0 / IDLE",
               name, bus.busy, bus.done, bus.mem_write_en, bus.mem_addr, bus.mem_write_data, dbg_state);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = OP_COPY; bus.src_addr = '0; bus.dst_addr = '0;
    bus.length = '0; bus.fill_value = '0;
    reset = 1'b0;
    clear_ref();
    #2;
    check_quiet("reset_state");
    bus.start = 1'b1;
    bus.length = 7'd5;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_held");
    bus.start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("reset_release");
  endtask

  task automatic test_fill();
    run_cmd(OP_FILL, 0, 10, 4, 8'hA5, 1'b0, 3);
  endtask

  task automatic test_copy();
    for (int i = 0; i < 4; i++) run_cmd(OP_FILL, 0, i, 1, 8'(i + 1), 1'b0, 3);
    run_cmd(OP_COPY, 0, 32, 4, 8'h00, 1'b0, 3);
  endtask

  task automatic test_wrap();
    run_cmd(OP_FILL, 0, 62, 4, 8'h3C, 1'b0, 3);
    run_cmd(OP_FILL, 0, 5, 100, 8'h5A, 1'b0, 3);
    run_cmd(OP_COPY, 60, 20, 8, 8'h00, 1'b0, 3);
  endtask

  task automatic test_zero_len();
    run_cmd(OP_COPY, 3, 40, 0, 8'h00, 1'b0, 3);
    run_cmd(OP_FILL, 0, 40, 0, 8'hFF, 1'b0, 3);
  endtask

  task automatic test_overlap();
    run_cmd(OP_FILL, 0, 0, 1, 8'h07, 1'b0, 3);
    run_cmd(OP_FILL, 0, 1, 3, 8'h00, 1'b0, 3);
    run_cmd(OP_COPY, 0, 1, 3, 8'h00, 1'b0, 3);
  endtask

  task automatic test_stray_start();
    run_cmd(OP_COPY, 0, 40, 5, 8'h00, 1'b1, 12);
    run_cmd(OP_FILL, 0, 50, 6, 8'hC3, 1'b1, 12);
  endtask

  task automatic test_back_to_back();
    run_cmd(OP_FILL, 0, 16, 3, 8'h11, 1'b0, 0);
    run_cmd(OP_COPY, 16, 24, 3, 8'h00, 1'b0, 0);
    run_cmd(OP_FILL, 0, 30, 0, 8'h22, 1'b0, 0);
    run_cmd(OP_FILL, 0, 31, 2, 8'h33, 1'b0, 3);
  endtask

  task automatic test_reset_mid_copy();
    bus.start = 1'b1; bus.op = OP_COPY; bus.src_addr = 6'd0; bus.dst_addr = 6'd32;
    bus.length = 7'd4; bus.fill_value = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_before_reset: got %b, required 1", bus.busy);
    end
    reset = 1'b0;
    #1;
    check_quiet("reset_mid_copy");
    clear_ref();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check_quiet("idle_after_reset");
      @(posedge clk); #1;
    end
    for (int i = 0; i < MS; i++) ref_mem[i] = '0;
  endtask

  task automatic test_random();
    int o, src, dst, len;
    for (int k = 0; k < 6; k++) run_cmd(OP_FILL, 0, $urandom_range(0, MS - 1), $urandom_range(1, 20), 8'($urandom), 1'b0, 3);
    for (int k = 0; k < 12; k++) begin
      o   = $urandom_range(0, 1);
      src = $urandom_range(0, MS - 1);
      dst = $urandom_range(0, MS - 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
      run_cmd(o[0], src, dst, len, 8'($urandom), 1'b0, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_zero_len();
    test_overlap();
    test_stray_start();
    test_back_to_back();
    test_reset_mid_copy();
    test_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
